uart_rx_controller: RTL and testbench

//  Sequences and configures the UART receiver: owns its Rx_EN and baud_select, applies baud changes only
//  at a quiet line, captures each valid byte into a FIFO, and records framing/parity errors.

---
 rtl/uart_rx_controller.sv | 256 +++++++++++++++++++++++++
 tb/tb_uart_rx_controller.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_controller.sv
// UART receiver sequencer: owns Rx_EN/baud_select, buffers bytes in a FWFT FIFO, tracks line errors.
// Latency: byte enters FIFO 2 clk after Rx_VALID rises; control outputs registered (1 clk).
// Backpressure: none toward receiver; byte dropped and overflow set when FIFO full without pop. Optional: UART_RX_ERR_COUNT_EN.

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end
endmodule

module uart_rx_controller #(
    parameter int FIFO_DEPTH   = 16,
    parameter int QUIET_CYCLES = 160
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cfg_enable,
    input  logic [2:0]                    cfg_baud,
    input  logic                          RxD,
    output logic [2:0]                    baud_select,
    output logic                          Rx_EN,
    input  logic [7:0]                    Rx_DATA,
    input  logic                          Rx_VALID,
    input  logic                          Rx_FERROR,
    input  logic                          Rx_PERROR,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          rd_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          ferr_flag,
    output logic                          perr_flag,
    input  logic                          status_clr,
    output logic [7:0]                    ferr_count,
    output logic [7:0]                    perr_count
);
    localparam int QW = $clog2(QUIET_CYCLES + 1);
    localparam logic [QW-1:0] QLAST = QW'(QUIET_CYCLES - 1);
    localparam logic [QW-1:0] QONE  = QW'(1);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_QUIET  = 2'd1,
        ST_RUN    = 2'd2,
        ST_RECONF = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [2:0]    baud_q, baud_d;
    logic          rx_en_q, rx_en_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_OFF;
            qcnt_q  <= '0;
            baud_q  <= 3'd0;
            rx_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            baud_q  <= baud_d;
            rx_en_q <= rx_en_d;
        end
    end

    // QUIET and RECONF share the idle-line window; only RECONF reloads the baud on exit.
    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        baud_d  = baud_q;
        case (state_q)
            ST_OFF: begin
                qcnt_d = '0;
                if (cfg_enable) begin
                    baud_d  = cfg_baud;
                    state_d = ST_QUIET;
                end
            end
            ST_QUIET, ST_RECONF: begin
                if (!cfg_enable) begin
                    state_d = ST_OFF;
                    qcnt_d  = '0;
                end else if (!RxD) begin
                    qcnt_d = '0;
                end else if (qcnt_q == QLAST) begin
                    qcnt_d = '0;
                    if (state_q == ST_RECONF) begin
                        baud_d  = cfg_baud;
                        state_d = ST_QUIET;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    qcnt_d = qcnt_q + QONE;
                end
            end
            ST_RUN: begin
                qcnt_d = '0;
                if (!cfg_enable) begin
                    state_d = ST_OFF;
                end else if (cfg_baud != baud_q) begin
                    state_d = ST_RECONF;
                end
            end
            default: begin
                state_d = ST_OFF;
                qcnt_d  = '0;
            end
        endcase
        rx_en_d = (state_d == ST_RUN);
    end

    assign baud_select = baud_q;
    assign Rx_EN       = rx_en_q;

    logic       vld_q;
    logic       push_vld;
    logic [7:0] push_dat;
    logic       fifo_full;
    logic       drop;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q    <= 1'b0;
            push_vld <= 1'b0;
            push_dat <= 8'h00;
        end else begin
            vld_q    <= Rx_VALID;
            push_vld <= Rx_VALID && !vld_q;
            push_dat <= Rx_DATA;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push_vld),
        .push_dat (push_dat),
        .pop      (rd_en),
        .pop_dat  (rd_data),
        .empty    (rd_empty),
        .full     (fifo_full),
        .count    (fifo_count)
    );

    assign drop = push_vld && fifo_full && !rd_en;

    logic ferr_q, perr_q;
    logic ferr_edge, perr_edge;

    assign ferr_edge = Rx_FERROR && !ferr_q;
    assign perr_edge = Rx_PERROR && !perr_q;

    // A same-cycle set beats status_clr so no event is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
            overflow  <= 1'b0;
            ferr_flag <= 1'b0;
            perr_flag <= 1'b0;
        end else begin
            ferr_q    <= Rx_FERROR;
            perr_q    <= Rx_PERROR;
            overflow  <= drop      || (overflow  && !status_clr);
            ferr_flag <= ferr_edge || (ferr_flag && !status_clr);
            perr_flag <= perr_edge || (perr_flag && !status_clr);
        end
    end

`ifdef UART_RX_ERR_COUNT_EN
    logic [7:0] ferr_cnt_q, perr_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ferr_cnt_q <= 8'h00;
            perr_cnt_q <= 8'h00;
        end else begin
            if (ferr_edge) begin
                if (ferr_cnt_q != 8'hFF) begin
                    ferr_cnt_q <= ferr_cnt_q + 8'h01;
                end
            end else if (status_clr) begin
                ferr_cnt_q <= 8'h00;
            end
            if (perr_edge) begin
                if (perr_cnt_q != 8'hFF) begin
                    perr_cnt_q <= perr_cnt_q + 8'h01;
                end
            end else if (status_clr) begin
                perr_cnt_q <= 8'h00;
            end
        end
    end

    assign ferr_count = ferr_cnt_q;
    assign perr_count = perr_cnt_q;
`else
    assign ferr_count = 8'h00;
    assign perr_count = 8'h00;
`endif
endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed bench for uart_rx_controller: sequencing, quiet window, FIFO, overflow, error flags.
module tb_uart_rx_controller;
    localparam int DEPTH = 16;
    localparam int QC    = 160;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_enable;
    logic [2:0] cfg_baud;
    logic       RxD;
    logic [2:0] baud_select;
    logic       Rx_EN;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_FERROR;
    logic       Rx_PERROR;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_empty;
    logic [4:0] fifo_count;
    logic       overflow;
    logic       ferr_flag;
    logic       perr_flag;
    logic       status_clr;
    logic [7:0] ferr_count;
    logic [7:0] perr_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx_controller #(.FIFO_DEPTH(DEPTH), .QUIET_CYCLES(QC)) dut (
        .clk(clk), .reset(reset), .cfg_enable(cfg_enable), .cfg_baud(cfg_baud), .RxD(RxD),
        .baud_select(baud_select), .Rx_EN(Rx_EN), .Rx_DATA(Rx_DATA), .Rx_VALID(Rx_VALID),
        .Rx_FERROR(Rx_FERROR), .Rx_PERROR(Rx_PERROR), .rd_en(rd_en), .rd_data(rd_data),
        .rd_empty(rd_empty), .fifo_count(fifo_count), .overflow(overflow),
        .ferr_flag(ferr_flag), .perr_flag(perr_flag), .status_clr(status_clr),
        .ferr_count(ferr_count), .perr_count(perr_count)
    );

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_byte(input logic [7:0] d);
        Rx_DATA = d; Rx_VALID = 1'b1; tick();
        Rx_VALID = 1'b0; tick();
    endtask

    task automatic test_reset;
        reset = 1'b1; cfg_enable = 1'b0; cfg_baud = 3'd0; RxD = 1'b1; Rx_DATA = 8'h00;
        Rx_VALID = 1'b0; Rx_FERROR = 1'b0; Rx_PERROR = 1'b0; rd_en = 1'b0; status_clr = 1'b0;
        tick(3);
        reset = 1'b0;
        tick();
        checks++; if (Rx_EN !== 1'b0) begin errors++; $display("FAIL reset_rx_en got %b exp 0", Rx_EN); end
        checks++; if (baud_select !== 3'd0) begin errors++; $display("FAIL reset_baud got %0d exp 0", baud_select); end
        checks++; if (rd_empty !== 1'b1 || fifo_count !== 5'd0) begin errors++; $display("FAIL reset_fifo got empty=%b count=%0d exp 1/0", rd_empty, fifo_count); end
        checks++; if ({overflow, ferr_flag, perr_flag} !== 3'b000 || ferr_count !== 8'd0 || perr_count !== 8'd0) begin
            errors++; $display("FAIL reset_status got %b%b%b %0d %0d exp 000 0 0", overflow, ferr_flag, perr_flag, ferr_count, perr_count);
        end
    endtask

    task automatic test_enable;
        cfg_baud = 3'd5; cfg_enable = 1'b1; RxD = 1'b1;
        tick();
        checks++; if (baud_select !== 3'd5) begin errors++; $display("FAIL enable_baud got %0d exp 5", baud_select); end
        tick(QC - 1);
        checks++; if (Rx_EN !== 1'b0) begin errors++; $display("FAIL enable_early got %b exp 0", Rx_EN); end
        tick();
        checks++; if (Rx_EN !== 1'b1) begin errors++; $display("FAIL enable_on got %b exp 1", Rx_EN); end
    endtask

    task automatic test_quiet_restart;
        cfg_enable = 1'b0; tick();
        checks++; if (Rx_EN !== 1'b0) begin errors++; $display("FAIL disable_rx_en got %b exp 0", Rx_EN); end
        cfg_enable = 1'b1; tick();
        tick(50);
        RxD = 1'b0; tick();
        RxD = 1'b1; tick(QC - 1);
        checks++; if (Rx_EN !== 1'b0) begin errors++; $display("FAIL restart_early got %b exp 0", Rx_EN); end
        tick();
        checks++; if (Rx_EN !== 1'b1) begin errors++; $display("FAIL restart_on got %b exp 1", Rx_EN); end
    endtask

    task automatic test_capture;
        Rx_DATA = 8'hA5; Rx_VALID = 1'b1; tick(4);
        Rx_VALID = 1'b0; tick(2);
        checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL capture_count got %0d exp 1", fifo_count); end
        checks++; if (rd_data !== 8'hA5 || rd_empty !== 1'b0) begin errors++; $display("FAIL capture_data got %h empty=%b exp a5/0", rd_data, rd_empty); end
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL pop_empty got %b exp 1", rd_empty); end
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL pop_while_empty got %0d exp 0", fifo_count); end
    endtask

    task automatic test_overflow;
        logic [7:0] exp_b;
        for (int i = 0; i <= DEPTH; i++) push_byte(8'h10 + 8'(i));
        checks++; if (fifo_count !== 5'(DEPTH)) begin errors++; $display("FAIL full_count got %0d exp %0d", fifo_count, DEPTH); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow got %b exp 1", overflow); end
        checks++; if (rd_data !== 8'h10) begin errors++; $display("FAIL full_head got %h exp 10", rd_data); end
        Rx_DATA = 8'hEE; Rx_VALID = 1'b1; tick();
        Rx_VALID = 1'b0; rd_en = 1'b1; tick(); rd_en = 1'b0;
        checks++; if (fifo_count !== 5'(DEPTH) || rd_data !== 8'h11) begin
            errors++; $display("FAIL push_pop_full got %0d/%h exp %0d/11", fifo_count, rd_data, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            exp_b = (i == DEPTH - 1) ? 8'hEE : 8'h11 + 8'(i);
            checks++; if (rd_data !== exp_b) begin errors++; $display("FAIL drain_%0d got %h exp %h", i, rd_data, exp_b); end
            rd_en = 1'b1; tick(); rd_en = 1'b0;
        end
        checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", rd_empty); end
    endtask

    task automatic test_errors;
        for (int i = 0; i < 3; i++) begin
            Rx_FERROR = 1'b1; tick(); Rx_FERROR = 1'b0; tick();
        end
        Rx_PERROR = 1'b1; tick(); Rx_PERROR = 1'b0; tick();
        checks++; if (ferr_flag !== 1'b1 || perr_flag !== 1'b1) begin errors++; $display("FAIL err_flags got %b%b exp 11", ferr_flag, perr_flag); end
`ifdef UART_RX_ERR_COUNT_EN
        checks++; if (ferr_count !== 8'd3 || perr_count !== 8'd1) begin errors++; $display("FAIL err_counts got %0d/%0d exp 3/1", ferr_count, perr_count); end
`else
        checks++; if (ferr_count !== 8'd0 || perr_count !== 8'd0) begin errors++; $display("FAIL err_counts got %0d/%0d exp 0/0", ferr_count, perr_count); end
`endif
        status_clr = 1'b1; tick(); status_clr = 1'b0;
        checks++; if ({overflow, ferr_flag, perr_flag} !== 3'b000 || ferr_count !== 8'd0 || perr_count !== 8'd0) begin
            errors++; $display("FAIL status_clr got %b%b%b %0d %0d exp 000 0 0", overflow, ferr_flag, perr_flag, ferr_count, perr_count);
        end
        Rx_FERROR = 1'b1; status_clr = 1'b1; tick(); Rx_FERROR = 1'b0; status_clr = 1'b0;
        checks++; if (ferr_flag !== 1'b1) begin errors++; $display("FAIL set_beats_clr got %b exp 1", ferr_flag); end
`ifdef UART_RX_ERR_COUNT_EN
        checks++; if (ferr_count !== 8'd1) begin errors++; $display("FAIL cnt_beats_clr got %0d exp 1", ferr_count); end
`endif
        status_clr = 1'b1; tick(); status_clr = 1'b0;
    endtask

    task automatic test_reconf;
        checks++; if (Rx_EN !== 1'b1) begin errors++; $display("FAIL pre_reconf got %b exp 1", Rx_EN); end
        cfg_baud = 3'd2; tick();
        checks++; if (Rx_EN !== 1'b0 || baud_select !== 3'd5) begin errors++; $display("FAIL reconf_entry got %b/%0d exp 0/5", Rx_EN, baud_select); end
        for (int i = 0; i < 20; i++) begin
            RxD = ~i[0]; tick();
        end
        RxD = 1'b1; tick(QC - 1);
        checks++; if (baud_select !== 3'd5 || Rx_EN !== 1'b0) begin errors++; $display("FAIL reconf_hold got %0d/%b exp 5/0", baud_select, Rx_EN); end
        tick();
        checks++; if (baud_select !== 3'd2 || Rx_EN !== 1'b0) begin errors++; $display("FAIL reconf_load got %0d/%b exp 2/0", baud_select, Rx_EN); end
        tick(QC - 1);
        checks++; if (Rx_EN !== 1'b0) begin errors++; $display("FAIL reconf_early got %b exp 0", Rx_EN); end
        tick();
        checks++; if (Rx_EN !== 1'b1 || baud_select !== 3'd2) begin errors++; $display("FAIL reconf_run got %b/%0d exp 1/2", Rx_EN, baud_select); end
    endtask

    task automatic test_reset_midframe;
        push_byte(8'h3C);
        checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL mid_push got %0d exp 1", fifo_count); end
        reset = 1'b1; tick(); reset = 1'b0;
        checks++; if (rd_empty !== 1'b1 || Rx_EN !== 1'b0 || baud_select !== 3'd0) begin
            errors++; $display("FAIL mid_reset got empty=%b en=%b baud=%0d exp 1/0/0", rd_empty, Rx_EN, baud_select);
        end
        tick(5);
        checks++; if (Rx_EN !== 1'b0 || baud_select !== 3'd2) begin errors++; $display("FAIL mid_quiet got %b/%0d exp 0/2", Rx_EN, baud_select); end
    endtask

    initial begin
        test_reset();
        test_enable();
        test_quiet_restart();
        test_capture();
        test_overflow();
        test_errors();
        test_reconf();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
